// File: rtl/sipo_unit.sv
// sipo_unit: serial-in / parallel-out shift register with word framing.
// Bits are shifted into q on every enabled clock edge. Every WIDTH
// enabled edges the completed word is copied to data_out, and byte_valid
// pulses for one cycle. All outputs come straight from registers.
module sipo_unit #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             shift_en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] data_out,
  output logic             byte_valid,
  output logic [CW-1:0]    bit_cnt
);

  // Count value held just before the edge that completes a word.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dataOut;
  logic             r_byteValid;
  logic [CW-1:0]    r_bitCnt;

  logic [WIDTH-1:0] w_qNext;
  logic             w_wordDone;

  // Shift direction: LSB-first pushes new bits in at the MSB so the oldest
  // bit drifts down to q[0]; MSB-first pushes in at the LSB instead.
  always_comb begin
    w_qNext = r_q;
    if (LSB_FIRST != 0) begin
      w_qNext = {data_in, r_q[WIDTH-1:1]};
    end else begin
      w_qNext = {r_q[WIDTH-2:0], data_in};
    end
  end

  // A word completes on the enabled edge that brings in its last bit.
  always_comb begin
    w_wordDone = shift_en && (r_bitCnt == LAST_CNT);
  end

  // Register update: reset wins over shifting; the valid pulse clears itself
  // on every edge that does not complete a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      r_dataOut   <= '0;
      r_byteValid <= 1'b0;
      r_bitCnt    <= '0;
    end else begin
      r_byteValid <= 1'b0;
      if (shift_en) begin
        r_q <= w_qNext;
        if (w_wordDone) begin
          r_bitCnt    <= '0;
          r_dataOut   <= w_qNext;
          r_byteValid <= 1'b1;
        end else begin
          r_bitCnt <= r_bitCnt + CW'(1);
        end
      end
    end
  end

  assign q          = r_q;
  assign data_out   = r_dataOut;
  assign byte_valid = r_byteValid;
  assign bit_cnt    = r_bitCnt;

endmodule

// File: tb/tb_sipo_unit.sv
// tb_sipo_unit: drives an LSB-first and an MSB-first sipo_unit from the same
// inputs and compares both against a history-based reference model.
module tb_sipo_unit;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          dataIn;
  logic          shiftEn;
  logic [W-1:0]  qL, dataOutL, qM, dataOutM;
  logic          validL, validM;
  logic [CW-1:0] cntL, cntM;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: every bit received since the last reset
  // (newest first), the number of enabled edges since reset, and the
  // last completed word as seen by each bit order.
  bit           histQ[$];
  int           edges;
  bit           mValid;
  logic [W-1:0] mOutL, mOutM;

  sipo_unit #(.WIDTH(W), .LSB_FIRST(1)) dutL (
    .clk(clk), .rst(rst), .data_in(dataIn), .shift_en(shiftEn),
    .q(qL), .data_out(dataOutL), .byte_valid(validL), .bit_cnt(cntL)
  );

  sipo_unit #(.WIDTH(W), .LSB_FIRST(0)) dutM (
    .clk(clk), .rst(rst), .data_in(dataIn), .shift_en(shiftEn),
    .q(qM), .data_out(dataOutM), .byte_valid(validM), .bit_cnt(cntM)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // The parallel view of the last W received bits. LSB-first: the bit
  // received k edges ago sits at position W-1-k; MSB-first: at position k.
  function automatic logic [W-1:0] modelQ(input bit lsbFirst);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < W && k < histQ.size(); k++) begin
      if (lsbFirst) v[W-1-k] = histQ[k];
      else          v[k]     = histQ[k];
    end
    return v;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic modelStep(input logic r, input logic s, input logic d);
    if (r) begin
      histQ.delete();
      edges  = 0;
      mValid = 1'b0;
      mOutL  = '0;
      mOutM  = '0;
    end else if (s) begin
      histQ.push_front(bit'(d));
      if (histQ.size() > W) void'(histQ.pop_back());
      edges++;
      mValid = ((edges % W) == 0);
      if (mValid) begin
        mOutL = modelQ(1'b1);
        mOutM = modelQ(1'b0);
      end
    end else begin
      mValid = 1'b0;
    end
  endtask

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Compare every output of both instances against the model.
  task automatic checkAll();
    checkOutput("lsb_q",     32'(qL),       32'(modelQ(1'b1)));
    checkOutput("lsb_dout",  32'(dataOutL), 32'(mOutL));
    checkOutput("lsb_valid", 32'(validL),   32'(mValid));
    checkOutput("lsb_cnt",   32'(cntL),     32'(edges % W));
    checkOutput("msb_q",     32'(qM),       32'(modelQ(1'b0)));
    checkOutput("msb_dout",  32'(dataOutM), 32'(mOutM));
    checkOutput("msb_valid", 32'(validM),   32'(mValid));
    checkOutput("msb_cnt",   32'(cntM),     32'(edges % W));
  endtask

  // Drive one cycle of inputs, step the model at the edge, check 1 unit later.
  task automatic applyStimulus(input logic r, input logic s, input logic d);
    rst     = r;
    shiftEn = s;
    dataIn  = d;
    @(posedge clk);
    modelStep(r, s, d);
    #1;
    checkAll();
  endtask

  // Shift a whole word in, bit 0 first.
  task automatic sendWordLsb(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) applyStimulus(1'b0, 1'b1, w[i]);
  endtask

  logic [W-1:0] seqA5;
  logic [W-1:0] seqC0;

  initial begin
    rst = 1'b1; shiftEn = 1'b1; dataIn = 1'b1;
    edges = 0; mValid = 1'b0; mOutL = '0; mOutM = '0;
    // bit i of these vectors is the i-th bit sent
    seqA5 = 8'b1010_0101;  // 1,0,1,0,0,1,0,1 (palindrome)
    seqC0 = 8'b0000_0011;  // 1,1,0,0,0,0,0,0

    // Reset held for two edges with shifting requested and data high.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("reset_q",   32'(qL),     32'h0);
    checkOutput("reset_cnt", 32'(cntL),   32'h0);
    checkOutput("reset_vld", 32'(validL), 32'h0);

    // Palindrome word, then a word that reads 0xC0 MSB-first.
    sendWordLsb(seqA5);
    checkOutput("a5_lsb_q",    32'(qL),       32'hA5);
    checkOutput("a5_lsb_dout", 32'(dataOutL), 32'hA5);
    checkOutput("a5_msb_dout", 32'(dataOutM), 32'hA5);
    checkOutput("a5_valid",    32'(validL),   32'h1);
    checkOutput("a5_cnt",      32'(cntL),     32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("a5_vld_drop", 32'(validL), 32'h0);
    sendWordLsb(seqC0);
    checkOutput("c0_msb_dout", 32'(dataOutM), 32'hC0);
    checkOutput("c0_lsb_dout", 32'(dataOutL), 32'h03);

    // Enable gating: 4 bits, 3 idle cycles with toggling data, 4 bits.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'(i % 2));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'(i % 2 == 0));
      checkOutput("gap_cnt", 32'(cntL),   32'h4);
      checkOutput("gap_vld", 32'(validL), 32'h0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'(i / 2));
    checkOutput("gate_dout", 32'(dataOutL), 32'hCA);

    // Mid-word reset: five 1s, reset, then 0x3C with no early pulse.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < W; i++) begin
      applyStimulus(1'b0, 1'b1, seqA5[0] & 1'b0 | (8'h3C >> i) & 1'b1);
      if (i < W - 1) checkOutput("mid_no_vld", 32'(validL), 32'h0);
    end
    checkOutput("mid_dout", 32'(dataOutL), 32'h3C);
    checkOutput("mid_vld",  32'(validL),   32'h1);

    // Streaming three words back to back.
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendWordLsb(8'h01);
    checkOutput("s1_dout", 32'(dataOutL), 32'h01);
    sendWordLsb(8'h80);
    checkOutput("s2_dout", 32'(dataOutL), 32'h80);
    sendWordLsb(8'hFF);
    checkOutput("s3_dout", 32'(dataOutL), 32'hFF);
    checkOutput("s3_vld",  32'(validL),   32'h1);

    // Randomized traffic with occasional resets and enable gaps.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 39) == 0),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sipo_unit.md
SIPO_UNIT -- requirements
Module: sipo_unit

Interface
REQ-001 Parameter: WIDTH, 8, parallel word width in bits (legal range 2..32).
REQ-002 Parameter: LSB_FIRST, 1, serial bit order. 1 = first received bit ends in q[0]. 0 = first received bit ends in q[WIDTH-1].
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: data_in  input  1  serial data bit, sampled on the rising clk edge.
REQ-006 Port: shift_en  input  1  when high, data_in is shifted in on this edge; when low, all state holds.
REQ-007 Port: q  output  WIDTH  live shift-register contents, updated on every enabled edge.
REQ-008 Port: data_out  output  WIDTH  last complete word, loaded only when a word completes.
REQ-009 Port: byte_valid  output  1  one-cycle pulse marking that data_out has just been loaded.
REQ-010 Port: bit_cnt  output  ceil(log2(WIDTH+1))  number of bits held in the current partial word.

Function
REQ-011 All outputs SHALL be registered; none combinationally depends on the inputs.
REQ-012 With LSB_FIRST=1, an enabled edge SHALL set q <= {data_in, q[WIDTH-1:1]} (right shift, new bit enters the MSB).
REQ-013 With LSB_FIRST=0, an enabled edge SHALL set q <= {q[WIDTH-2:0], data_in} (left shift, new bit enters the LSB).
REQ-014 With shift_en=0, q, bit_cnt and data_out SHALL hold, and byte_valid SHALL be 0.
REQ-015 On an enabled edge with bit_cnt < WIDTH-1, bit_cnt SHALL increment by 1.
REQ-016 On an enabled edge with bit_cnt = WIDTH-1 (word-completing edge):
- bit_cnt SHALL wrap to 0;
- data_out SHALL load the post-shift q value;
- byte_valid SHALL be 1 for exactly the following cycle.
REQ-017 On a word-completing edge, data_out SHALL equal the new q value in the same cycle; latency is 0 cycles after the final bit's edge.
REQ-018 Back-to-back words with continuous shift_en SHALL be supported with no gap cycles; byte_valid pulses once every WIDTH enabled edges.
REQ-019 byte_valid SHALL NOT remain high for two consecutive cycles unless WIDTH enabled edges elapse between them (impossible for WIDTH≥2).
REQ-020 q SHALL keep shifting across word boundaries; it is not cleared at word completion.
REQ-021 An X/Z value on data_in is not required to be filtered; it propagates as sampled.

Reset
REQ-022 When rst=1 at a rising edge: q=0, data_out=0, bit_cnt=0, byte_valid=0, regardless of shift_en.
REQ-023 rst SHALL take priority over shift_en on the same edge; the data_in bit at that edge is discarded.
REQ-024 Reset mid-word SHALL discard the partial word. The next word starts counting from the first enabled edge after rst deasserts.
REQ-025 Outputs are undefined before the first reset edge; a bench applies rst for at least one clk edge.

Verification
REQ-026 Reset: assert rst for 2 edges with shift_en=1, data_in=1 -> q=0x00, data_out=0x00, bit_cnt=0, byte_valid=0.
REQ-027 LSB_FIRST=1, shift_en=1, data_in sequence 1,0,1,0,0,1,0,1 -> after the 8th edge q=0xA5, data_out=0xA5, byte_valid=1 for one cycle, bit_cnt=0.
REQ-028 LSB_FIRST=0, same bit sequence -> after the 8th edge q=0xA5 reversed = 0xA5 (palindrome check), then sequence 1,1,0,0,0,0,0,0 -> data_out=0xC0.
REQ-029 Enable gating: drive 4 bits, hold shift_en=0 for 3 cycles with data_in toggling, then 4 more bits.
- Required: q and bit_cnt frozen during the gap.
- Required: byte_valid only after the 8th enabled edge, with the correct word.
REQ-030 Mid-word reset: shift 5 bits of 1, pulse rst for 1 edge, then shift 0x3C LSB-first -> data_out=0x3C after exactly 8 enabled edges, with no earlier byte_valid.
REQ-031 Streaming: 3 consecutive words 0x01, 0x80, 0xFF with continuous shift_en -> byte_valid pulses at edges 8, 16 and 24, data_out matching each word.
